// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared bus widths, stall encodings, load_op bit positions and bus layouts for the MEM stage
package mem_stage_pkg;
  localparam int EX_TO_MEM_WD = 81;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_RF_WD = 38;
  localparam int STALL_WD = 6;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam int LB = 4;
  localparam int LBU = 3;
  localparam int LH = 2;
  localparam int LHU = 1;
  localparam int LW = 0;
  typedef struct packed {
    logic [4:0] load_op;
    logic [31:0] pc;
    logic ram_en;
    logic [3:0] ram_wen;
    logic sel_rf_res;
    logic rf_we;
    logic [4:0] rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: stall vector, EX->MEM bus, SRAM read data in; MEM->WB and MEM->ID forwarding buses out
interface mem_stage_if;
  import mem_stage_pkg::*;
  logic [STALL_WD-1:0] stall;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [31:0] data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus;
  modport master (output stall, ex_to_mem_bus, data_sram_rdata, input mem_to_wb_bus, mem_to_rf_bus);
  modport slave (input stall, ex_to_mem_bus, data_sram_rdata, output mem_to_wb_bus, mem_to_rf_bus);
endinterface

// File: rtl/mem_load_align.sv
// mem_load_align: picks byte/half/word from rdata at offset and sign/zero extends per one-hot load_op
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [4:0]  load_op,
  output logic [31:0] wdata
);
  logic [31:0] sh;
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    sh = rdata >> {offset, 3'b000};
    b = sh[7:0];
    h = offset[1] ? rdata[31:16] : rdata[15:0];
    wdata = load_op[LB]  ? {{24{b[7]}}, b} :
            load_op[LBU] ? {24'b0, b} :
            load_op[LH]  ? {{16{h[15]}}, h} :
            load_op[LHU] ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX->MEM register, SRAM read-data hold across stalls, load align, MEM->WB/forwarding buses
// ports: clk, rst (sync, active-high), bus (mem_stage_if.slave)
module mem_stage
  import mem_stage_pkg::*;
(
  input logic clk,
  input logic rst,
  mem_stage_if.slave bus
);
  ex_to_mem_t bus_r;
  logic first_cyc, buf_vld, stop, bubble;
  logic [31:0] rdata_buf, rd, ld, wdata;
  logic unused_ok;
  assign stop = bus.stall[3] == STOP;
  assign bubble = stop && bus.stall[4] == NO_STOP;
  // SRAM data is only valid the first cycle a load sits here, so capture it if that cycle is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_r <= '0;
      first_cyc <= 1'b0;
      buf_vld <= 1'b0;
      rdata_buf <= '0;
    end else if (bubble) begin
      bus_r <= '0;
      first_cyc <= 1'b0;
      buf_vld <= 1'b0;
    end else if (!stop) begin
      bus_r <= ex_to_mem_t'(bus.ex_to_mem_bus);
      first_cyc <= 1'b1;
      buf_vld <= 1'b0;
    end else begin
      first_cyc <= 1'b0;
      if (first_cyc && bus_r.sel_rf_res) begin
        rdata_buf <= bus.data_sram_rdata;
        buf_vld <= 1'b1;
      end
    end
  end
  assign rd = buf_vld ? rdata_buf : bus.data_sram_rdata;
  mem_load_align u_align (
    .rdata(rd),
    .offset(bus_r.ex_result[1:0]),
    .load_op(bus_r.load_op),
    .wdata(ld)
  );
  assign wdata = bus_r.sel_rf_res ? ld : bus_r.ex_result;
  assign bus.mem_to_wb_bus = {bus_r.pc, bus_r.rf_we, bus_r.rf_waddr, wdata};
  assign bus.mem_to_rf_bus = {bus_r.rf_we, bus_r.rf_waddr, wdata};
  assign unused_ok = ^{bus_r.ram_en, bus_r.ram_wen, bus.stall[2:0], bus.stall[5]};
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors with hand-computed expectations for mem_stage
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst;
  int n_vec = 0;
  int n_err = 0;
  mem_stage_if bus();
  mem_stage dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  localparam logic [5:0] RUN = 6'b000000;
  localparam logic [5:0] HOLD = 6'b011000;
  localparam logic [5:0] BUBBLE = 6'b001000;
  function automatic logic [80:0] mk(input logic [4:0] op, input logic [31:0] pc, input logic ram_en,
                                     input logic [3:0] wen, input logic sel, input logic we,
                                     input logic [4:0] wa, input logic [31:0] res);
    return {op, pc, ram_en, wen, sel, we, wa, res};
  endfunction
  function automatic logic [69:0] wb(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                                     input logic [31:0] wd);
    return {pc, we, wa, wd};
  endfunction
  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_both(input string tag, input logic [31:0] pc, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd);
    #1;
    check({tag, "_wb"}, bus.mem_to_wb_bus, wb(pc, we, wa, wd));
    check({tag, "_rf"}, {32'b0, bus.mem_to_rf_bus}, {32'b0, we, wa, wd});
  endtask
  task automatic load(input string tag, input logic [4:0] op, input logic [31:0] pc, input logic [4:0] wa,
                      input logic [31:0] addr, input logic [31:0] rdata, input logic [31:0] exp);
    bus.ex_to_mem_bus = mk(op, pc, 1'b1, 4'h0, 1'b1, 1'b1, wa, addr);
    cyc();
    bus.ex_to_mem_bus = '0;
    bus.data_sram_rdata = rdata;
    chk_both(tag, pc, 1'b1, wa, exp);
  endtask
  initial begin
    rst = 1'b1;
    bus.stall = RUN;
    bus.ex_to_mem_bus = '0;
    bus.data_sram_rdata = 32'h5555_AAAA;
    cyc();
    cyc();
    rst = 1'b0;
    chk_both("reset", 32'h0, 1'b0, 5'd0, 32'h0);
    load("lw", 5'b00001, 32'h100, 5'd3, 32'h1000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    load("lb3", 5'b10000, 32'h104, 5'd4, 32'h1003, 32'h80FF_0000, 32'hFFFF_FF80);
    load("lbu3", 5'b01000, 32'h108, 5'd4, 32'h1003, 32'h80FF_0000, 32'h0000_0080);
    load("lbu2", 5'b01000, 32'h10C, 5'd4, 32'h1002, 32'h80FF_0000, 32'h0000_00FF);
    load("lh2", 5'b00100, 32'h110, 5'd6, 32'h1002, 32'h80FF_0000, 32'hFFFF_80FF);
    load("lhu3", 5'b00010, 32'h114, 5'd6, 32'h1003, 32'h80FF_0000, 32'h0000_80FF);
    load("lh0", 5'b00100, 32'h118, 5'd6, 32'h1000, 32'h80FF_8001, 32'hFFFF_8001);
    load("lb1", 5'b10000, 32'h11C, 5'd2, 32'h1001, 32'h0000_7F00, 32'h0000_007F);
    // load held for three stalled cycles while SRAM data goes away
    bus.ex_to_mem_bus = mk(5'b00001, 32'h120, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8, 32'h2000);
    cyc();
    bus.ex_to_mem_bus = mk(5'b00000, 32'h124, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'h9999);
    bus.stall = HOLD;
    bus.data_sram_rdata = 32'hDEAD_BEEF;
    chk_both("hold0", 32'h120, 1'b1, 5'd8, 32'hDEAD_BEEF);
    cyc();
    bus.data_sram_rdata = 32'h0;
    chk_both("hold1", 32'h120, 1'b1, 5'd8, 32'hDEAD_BEEF);
    cyc();
    chk_both("hold2", 32'h120, 1'b1, 5'd8, 32'hDEAD_BEEF);
    bus.stall = RUN;
    cyc();
    bus.ex_to_mem_bus = '0;
    chk_both("after_hold", 32'h124, 1'b1, 5'd9, 32'h9999);
    // bubble inserted while the buffer holds load data
    bus.ex_to_mem_bus = mk(5'b00001, 32'h200, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7, 32'h3000);
    cyc();
    bus.stall = HOLD;
    bus.data_sram_rdata = 32'hCAFE_F00D;
    chk_both("pre_bub0", 32'h200, 1'b1, 5'd7, 32'hCAFE_F00D);
    cyc();
    bus.data_sram_rdata = 32'h0;
    bus.stall = BUBBLE;
    chk_both("pre_bub1", 32'h200, 1'b1, 5'd7, 32'hCAFE_F00D);
    cyc();
    chk_both("bubble", 32'h0, 1'b0, 5'd0, 32'h0);
    bus.stall = RUN;
    load("post_bub", 5'b00001, 32'h204, 5'd7, 32'h3004, 32'h1111_2222, 32'h1111_2222);
    // ALU result and store pass through
    bus.ex_to_mem_bus = mk(5'b00000, 32'h300, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h1234);
    cyc();
    bus.ex_to_mem_bus = mk(5'b00000, 32'h304, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h40);
    bus.data_sram_rdata = 32'hFFFF_FFFF;
    chk_both("alu", 32'h300, 1'b1, 5'd5, 32'h1234);
    cyc();
    bus.ex_to_mem_bus = '0;
    chk_both("store", 32'h304, 1'b0, 5'd0, 32'h40);
    // reset during a held load
    bus.ex_to_mem_bus = mk(5'b00001, 32'h400, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h5000);
    cyc();
    bus.stall = HOLD;
    bus.data_sram_rdata = 32'hA5A5_A5A5;
    chk_both("rst_hold0", 32'h400, 1'b1, 5'd9, 32'hA5A5_A5A5);
    cyc();
    bus.data_sram_rdata = 32'h0;
    rst = 1'b1;
    chk_both("rst_hold1", 32'h400, 1'b1, 5'd9, 32'hA5A5_A5A5);
    cyc();
    rst = 1'b0;
    chk_both("rst_mid", 32'h0, 1'b0, 5'd0, 32'h0);
    bus.stall = RUN;
    load("post_rst", 5'b00001, 32'h404, 5'd10, 32'h5004, 32'h1234_5678, 32'h1234_5678);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
